// File: rtl/cmd_parser_pkg.sv
// cmd_parser_pkg: parser states, frame header and the acquisition configuration word field map.
package cmd_parser_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_PAYLOAD, ST_CHECK} state_e;
    localparam logic [7:0] CMD_HDR_CONFIG = 8'h43;
    localparam int CFG_W          = 29;
    localparam int TRIG_LEVEL_OFF = 0;
    localparam int TRIG_LEVEL_W   = 8;
    localparam int TRIG_EDGE_OFF  = 8;
    localparam int TRIG_EDGE_W    = 1;
    localparam int TRIG_EN_OFF    = 9;
    localparam int TRIG_EN_W      = 1;
    localparam int PRETRIG_OFF    = 10;
    localparam int PRETRIG_W      = 10;
    localparam int DECIM_OFF      = 20;
    localparam int DECIM_W        = 9;
    function automatic logic rsvd_clear(input logic [31:0] w);
        return w[31:CFG_W] == '0;
    endfunction
endpackage

// File: rtl/cmd_parser_idle_timer.sv
// idle_timer: inter-byte idle counter; expired flags the cycle whose edge brings the count to LIMIT.
module idle_timer #(
    parameter int WIDTH = 18,
    parameter int LIMIT = 250_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expired
);
    logic [WIDTH-1:0] cnt_q, cnt_d;
    always_comb cnt_d = clear ? '0 : run ? cnt_q + WIDTH'(1) : cnt_q;
    assign expired = run && !clear && cnt_q == WIDTH'(LIMIT - 1);
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
endmodule

// File: rtl/cmd_parser.sv
// cmd_parser: recognises 'C' configuration frames from the UART and commits a 29-bit acquisition word.
// Optional checksum byte and CHECK state are built only when CMD_CHECKSUM_EN is defined.
module cmd_parser
    import cmd_parser_pkg::*;
#(
    parameter int               TIMEOUT_CYCLES = 250_000,
    parameter int               VALID_HOLD     = 4,
    parameter logic [CFG_W-1:0] DEFAULT_CFG    = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_data_fresh,
    output logic [CFG_W-1:0] configuration,
    output logic             configuration_valid,
    output logic             frame_error
);
    localparam int         TW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [3:0] HOLD = 4'(VALID_HOLD);
    state_e           state_q;
    logic [1:0]       idx_q;
    logic [23:0]      lo_q;
    logic [3:0]       hold_q;
    logic [CFG_W-1:0] cfg_q;
    logic             valid_q, err_q, expired, done, ok;
    logic [31:0]      word;
`ifdef CMD_CHECKSUM_EN
    logic [7:0]       p3_q, xor_q;
    assign word = {p3_q, lo_q};
    assign done = rx_data_fresh && state_q == ST_CHECK;
    assign ok   = rsvd_clear(word) && rx_data == xor_q;
`else
    // P3 is taken straight from the bus so the commit lands on the edge after it.
    assign word = {rx_data, lo_q};
    assign done = rx_data_fresh && state_q == ST_PAYLOAD && idx_q == 2'd3;
    assign ok   = rsvd_clear(word);
`endif
    idle_timer #(.WIDTH(TW), .LIMIT(TIMEOUT_CYCLES)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (rx_data_fresh || state_q == ST_IDLE),
        .run     (state_q != ST_IDLE),
        .expired (expired)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            lo_q    <= '0;
            hold_q  <= '0;
            cfg_q   <= DEFAULT_CFG;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
`ifdef CMD_CHECKSUM_EN
            p3_q    <= '0;
            xor_q   <= '0;
`endif
        end else begin
            err_q   <= expired || (done && !ok);
            valid_q <= (done && ok) || hold_q > 4'd1;
            hold_q  <= (done && ok) ? HOLD : hold_q - ((hold_q != '0) ? 4'd1 : 4'd0);
            if (done && ok) cfg_q <= word[CFG_W-1:0];
            if (expired || done) begin
                state_q <= ST_IDLE;
            end else if (rx_data_fresh && state_q == ST_IDLE && rx_data == CMD_HDR_CONFIG) begin
                state_q <= ST_PAYLOAD;
                idx_q   <= '0;
`ifdef CMD_CHECKSUM_EN
                xor_q   <= '0;
`endif
            end else if (rx_data_fresh && state_q == ST_PAYLOAD) begin
                idx_q <= idx_q + 2'd1;
                if (idx_q != 2'd3) lo_q <= {rx_data, lo_q[23:8]};
`ifdef CMD_CHECKSUM_EN
                xor_q <= xor_q ^ rx_data;
                if (idx_q == 2'd3) begin
                    p3_q    <= rx_data;
                    state_q <= ST_CHECK;
                end
`endif
            end
        end
    end
    assign configuration       = cfg_q;
    assign configuration_valid = valid_q;
    assign frame_error         = err_q;
endmodule

// File: tb/tb_cmd_parser.sv
// tb_cmd_parser: directed scenarios plus random frames, checked every cycle against a byte-queue model.
module tb_cmd_parser;
    localparam int          TMO  = 20;
    localparam int          HOLD = 4;
    localparam logic [28:0] DEF  = 29'h0155_00AA;
`ifdef CMD_CHECKSUM_EN
    localparam int NB = 5;
`else
    localparam int NB = 4;
`endif
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_data_fresh = 1'b0;
    logic [28:0] configuration;
    logic        configuration_valid;
    logic        frame_error;
    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;
    bit          m_in;
    logic [7:0]  m_bytes[$];
    int          m_idle;
    logic [28:0] m_cfg;
    int          m_left;
    bit          m_err;

    cmd_parser #(.TIMEOUT_CYCLES(TMO), .VALID_HOLD(HOLD), .DEFAULT_CFG(DEF)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .rx_data             (rx_data),
        .rx_data_fresh       (rx_data_fresh),
        .configuration       (configuration),
        .configuration_valid (configuration_valid),
        .frame_error         (frame_error)
    );

    always #5 clk = ~clk;

    // Expected outputs after the coming edge, from the frame rules alone.
    task automatic model_step(input logic f, input logic [7:0] d, input logic r);
        logic [31:0] w;
        logic        ok;
        if (r) begin
            m_in = 0; m_bytes.delete(); m_idle = 0; m_cfg = DEF; m_left = 0; m_err = 0;
            return;
        end
        m_err = 0;
        if (m_left > 0) m_left--;
        if (f) begin
            m_idle = 0;
            if (!m_in) m_in = (d == 8'h43);
            else begin
                m_bytes.push_back(d);
                if (m_bytes.size() == NB) begin
                    w  = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
                    ok = (w[31:29] == 3'b000);
`ifdef CMD_CHECKSUM_EN
                    ok = ok && (m_bytes[4] == (m_bytes[0] ^ m_bytes[1] ^ m_bytes[2] ^ m_bytes[3]));
`endif
                    if (ok) begin m_cfg = w[28:0]; m_left = HOLD; end
                    else m_err = 1;
                    m_in = 0;
                    m_bytes.delete();
                end
            end
        end else if (m_in) begin
            m_idle++;
            if (m_idle == TMO) begin m_err = 1; m_in = 0; m_bytes.delete(); m_idle = 0; end
        end
    endtask

    always @(posedge clk) if (chk_on) begin
        #2;
        n_cmp++;
        if (configuration !== m_cfg) begin n_bad++; $display("FAIL model_cfg @%0t: dut=%h model=%h", $time, configuration, m_cfg); end
        n_cmp++;
        if (configuration_valid !== (m_left > 0)) begin n_bad++; $display("FAIL model_valid @%0t: dut=%b model=%b", $time, configuration_valid, m_left > 0); end
        n_cmp++;
        if (frame_error !== m_err) begin n_bad++; $display("FAIL model_err @%0t: dut=%b model=%b", $time, frame_error, m_err); end
    end

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin n_bad++; $display("FAIL %s: dut=%h expected=%h", nm, act, exp); end
    endfunction

    task automatic step(input logic f, input logic [7:0] d, input logic r);
        @(negedge clk);
        rx_data_fresh = f; rx_data = d; rst = r;
        model_step(f, d, r);
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
    endtask
    task automatic send(input logic [7:0] b);
        step(1'b1, b, 1'b0);
    endtask
    task automatic at_edge();
        @(posedge clk);
        #1;
    endtask
    task automatic send_frame(input logic [31:0] wi, input logic bad, input int gap);
        logic [31:0] w;
        w = wi;
`ifndef CMD_CHECKSUM_EN
        if (bad) w[29] = 1'b1;
`endif
        send(8'h43);
        for (int i = 0; i < 4; i++) begin idle(gap); send(w[8*i +: 8]); end
`ifdef CMD_CHECKSUM_EN
        idle(gap);
        send(bad ? 8'h00 : (w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24]));
`endif
    endtask

    initial begin
        step(1'b0, 8'h00, 1'b1);
        chk_on = 1'b1;
        step(1'b0, 8'h00, 1'b1);
        at_edge();
        chk("reset_cfg", 32'(configuration), 32'(DEF));
        chk("reset_valid", 32'(configuration_valid), 0);
        chk("reset_err", 32'(frame_error), 0);
        // Valid frame.
        send_frame(32'h0756_3412, 1'b0, 0);
        at_edge();
        chk("s1_cfg", 32'(configuration), 32'h0756_3412);
        chk("s1_valid", 32'(configuration_valid), 1);
        chk("s1_err", 32'(frame_error), 0);
        idle(6);
        // Bad checksum (reserved bit when checksum is not built).
        send_frame(32'h0756_3412, 1'b1, 0);
        at_edge();
        chk("s2_err", 32'(frame_error), 1);
        chk("s2_cfg", 32'(configuration), 32'h0756_3412);
        chk("s2_valid", 32'(configuration_valid), 0);
        idle(3);
        send_frame(32'h2000_0000, 1'b0, 0);
        at_edge();
        chk("s3_err", 32'(frame_error), 1);
        chk("s3_cfg", 32'(configuration), 32'h0756_3412);
        idle(3);
        // Timeout then recovery.
        send(8'h43); send(8'h12); send(8'h34);
        idle(TMO);
        at_edge();
        chk("s4_timeout_err", 32'(frame_error), 1);
        idle(2);
        send_frame(32'h0756_3412, 1'b0, 0);
        at_edge();
        chk("s4_recover_valid", 32'(configuration_valid), 1);
        idle(6);
        // Noise then frame.
        send(8'hFF); send(8'h00); send(8'h5A);
        send_frame(32'h0756_3412, 1'b0, 0);
        at_edge();
        chk("s5_err", 32'(frame_error), 0);
        chk("s5_valid", 32'(configuration_valid), 1);
        idle(6);
        // Byte lands exactly in the expiry cycle.
        send(8'h43); send(8'h12);
        idle(TMO - 1);
        send(8'h34);
        at_edge();
        chk("s5_edge_err", 32'(frame_error), 0);
        send(8'h56); send(8'h07);
`ifdef CMD_CHECKSUM_EN
        send(8'h77);
`endif
        at_edge();
        chk("s5_edge_valid", 32'(configuration_valid), 1);
        idle(6);
        // Reset mid-frame.
        send(8'h43); send(8'h12);
        step(1'b0, 8'h00, 1'b1);
        at_edge();
        chk("s6_cfg_default", 32'(configuration), 32'(DEF));
        chk("s6_err", 32'(frame_error), 0);
        send_frame(32'h0756_3412, 1'b0, 0);
        at_edge();
        chk("s6_cfg", 32'(configuration), 32'h0756_3412);
        // Random traffic, including back-to-back frames and gaps around the timeout.
        for (int n = 0; n < 300; n++) begin
            int          k, g;
            logic [31:0] w;
            k = $urandom_range(0, 15);
            w = $urandom;
            if (k < 10) w[31:29] = 3'b000;
            g = ($urandom_range(0, 7) == 0) ? TMO - 2 + $urandom_range(0, 3) : $urandom_range(0, 2);
            if (k == 14) send(8'($urandom_range(0, 255)));
            else if (k == 15) step(1'b0, 8'h00, 1'b1);
            else send_frame(w, $urandom_range(0, 7) == 0, g);
            idle($urandom_range(0, 6));
        end
        idle(8);
        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/cmd_parser.md
# cmd_parser

- Receives host bytes from the UART receiver and recognises configuration frames.
- Each valid frame yields a 29-bit acquisition configuration word and a stretched `configuration_valid` strobe.
- Sits between the UART `rx_data`/`rx_data_fresh` outputs and the clk_FPGA→clk_ADC synchronizer that feeds `acquire`.
- Runs entirely in the clk_FPGA domain.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 250_000: maximum idle cycles between bytes of one frame (10 ms at 25 MHz) before the frame is abandoned.
- `VALID_HOLD`, 4: number of cycles `configuration_valid` stays high after a commit. Legal range 1..15.
- `DEFAULT_CFG`, 29'h0: value of `configuration` after reset.

Ports (one clock; reset is synchronous and active-high):
- `clk` input 1: clk_FPGA.
- `rst` input 1: synchronous, active-high reset.
- `rx_data` input 8: received byte, valid when `rx_data_fresh` is high.
- `rx_data_fresh` input 1: one-cycle strobe per received byte.
- `configuration` output 29: last committed configuration word, registered.
- `configuration_valid` output 1: high for `VALID_HOLD` cycles after a commit.
- `frame_error` output 1: one-cycle pulse when a started frame is rejected.

## Operation
Frame format:
- Header 0x43 ('C').
- Four payload bytes P0..P3, little-endian, forming word W[31:0].
- Checksum byte equal to P0^P1^P2^P3 (only when `CMD_CHECKSUM_EN` is defined).

Configuration field map for W[28:0]:
- [7:0] trigger level.
- [8] trigger edge: 0 = rising, 1 = falling.
- [9] trigger enable.
- [19:10] pretrigger sample count.
- [28:20] decimation.
- W[31:29] are reserved and must be 0.

States:
- IDLE: a byte equal to 0x43 moves to PAYLOAD with byte index 0. Any other byte is ignored silently, with no error.
- PAYLOAD: each fresh byte is stored at the current index, and the index increments. After P3:
  - with the checksum feature, go to CHECK;
  - without it, validate and go to IDLE.
- CHECK: the next fresh byte is compared with the running XOR, then validate and go to IDLE.

Validate:
- Passes only if the checksum matches (when enabled) and W[31:29] == 0.
- Pass → commit: `configuration` ← W[28:0], hold counter loaded with `VALID_HOLD`.
- Fail → pulse `frame_error`; `configuration` is unchanged.

Timeout:
- The inter-byte counter clears on every fresh byte and on entry to IDLE.
- It counts only outside IDLE.
- When it reaches `TIMEOUT_CYCLES` with no fresh byte that cycle: pulse `frame_error`, go to IDLE, discard partial payload.

A 0x43 byte received inside a frame is treated as data; there is no resynchronisation on the header.

## Timing
Reset values:
- `configuration` = `DEFAULT_CFG`.
- `configuration_valid` = 0.
- `frame_error` = 0.
- State IDLE, index 0, timers 0.

Commit latency:
- `configuration` and `configuration_valid` update on the clock edge after the cycle in which the final byte's `rx_data_fresh` is high.
- `configuration` is stable from that edge until the next commit.

`configuration_valid`:
- Stays high for exactly `VALID_HOLD` consecutive cycles.
- A commit while the strobe is still high reloads the hold counter and updates `configuration`.

`frame_error`:
- One cycle wide.
- Issued on the same edge a commit would have been issued.
- On timeout, issued on the edge where the counter reaches `TIMEOUT_CYCLES`.

Simultaneous events:
- A fresh byte and timeout expiry in the same cycle: the byte wins, the counter clears, and no error is raised.
- `rst` has priority over everything. Reset mid-frame drops the frame with no error pulse and restores `DEFAULT_CFG`.

Back-to-back frames: a header in the cycle directly after the commit is accepted.

## Configuration
- `CMD_CHECKSUM_EN` defined:
  - six-byte frames;
  - CHECK state and XOR accumulator present;
  - checksum mismatch raises `frame_error`.
- `CMD_CHECKSUM_EN` undefined:
  - five-byte frames;
  - CHECK state and accumulator removed;
  - only the reserved-bit check can raise `frame_error`.

## Structure
Package `cmd_parser_pkg` holds:
- the state enum;
- `CMD_HDR_CONFIG` = 8'h43;
- the field offsets and widths of the configuration word (trigger level, edge, enable, pretrigger, decimation);
- `CFG_W` = 29.

`acquire` and the top level import the same package.

One sub-module, `idle_timer`:
- parameterised width, derived as clog2(`TIMEOUT_CYCLES`+1);
- inputs clear and run; output expired.
The FSM, payload shift register and hold counter stay in `cmd_parser`.

## Test plan
1. Valid frame (checksum enabled): 43,12,34,56,07,77.
   - `configuration` = 29'h07563412 on the edge after the 77 strobe.
   - `configuration_valid` high for 4 cycles; no `frame_error`.
2. Bad checksum: 43,12,34,56,07,00.
   - One-cycle `frame_error`; `configuration` stays at its prior value; no valid strobe.
3. Reserved bits: 43,00,00,00,20,20.
   - `frame_error`; configuration unchanged.
4. Timeout and recovery: send 43,12,34, then idle `TIMEOUT_CYCLES` cycles.
   - `frame_error` at expiry, state IDLE.
   - The scenario-1 frame sent next commits normally.
5. Noise before header: FF,00,5A, then the scenario-1 frame.
   - No error; frame commits.
   - Separately, a byte arriving exactly at the expiry cycle must not trigger a timeout.
6. Reset mid-frame: 43,12, then `rst` for 1 cycle, then the scenario-1 frame.
   - `configuration` = `DEFAULT_CFG` after reset; no error pulse.
   - The new frame commits 07563412.
